word_deframer: RTL and testbench

- Consumes the 32-bit word stream produced by the 8-to-32 width converter and recovers framed packets.
- Hunts for a sync word, then parses a header word carrying length and sequence number.
- Forwards payload words downstream with a last marker, then checks a trailing additive checksum.
- Reports per-frame status pulses and saturating statistics counters to the control/CSR layer.

---
 rtl/word_deframer.sv | 183 ++++++++++++++++++
 tb/tb_word_deframer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_deframer.sv
// Recovers framed packets (sync, header, payload, checksum) from a 32-bit word stream,
// forwarding payload through a single output register and reporting per-frame status.
module word_deframer #(
    parameter logic [31:0] SYNC_WORD = 32'hC0FFEE5A,
    parameter int          MAX_LEN   = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      t0_data,
    input  logic             t0_valid,
    output logic             t0_ready,
    output logic [31:0]      i0_data,
    output logic             i0_valid,
    output logic             i0_last,
    input  logic             i0_ready,
    output logic [15:0]      frame_seq,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             seq_gap,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int               LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [15:0]      MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [LEN_W-1:0] REM_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {S_HUNT, S_HDR, S_PAY, S_CHK} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [31:0]      acc_q, acc_d;
    logic [15:0]      prev_seq_q, prev_seq_d;
    logic             seq_seen_q, seq_seen_d;
    logic [15:0]      seq_q, seq_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             gap_q, gap_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic        accept;
    logic [15:0] hdr_len;
    logic [15:0] hdr_seq;
    logic        len_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Payload may only enter when the output register is empty or draining this cycle.
    assign t0_ready = (state_q == S_PAY) ? (!valid_q || i0_ready) : 1'b1;
    assign accept   = t0_valid && t0_ready;
    assign hdr_len  = t0_data[31:16];
    assign hdr_seq  = t0_data[15:0];
    assign len_bad  = (hdr_len == 16'd0) || (hdr_len > MAX_LEN_W);

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        acc_d      = acc_q;
        prev_seq_d = prev_seq_q;
        seq_seen_d = seq_seen_q;
        seq_d      = seq_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        gap_d      = 1'b0;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (valid_q && i0_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                S_HUNT: begin
                    if (t0_data == SYNC_WORD) begin
                        state_d = S_HDR;
                    end else begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end
                end
                S_HDR: begin
                    // Sequence continuity is tracked for every header, even ones rejected for length.
                    gap_d      = seq_seen_q && (hdr_seq != prev_seq_q + 16'd1);
                    prev_seq_d = hdr_seq;
                    seq_seen_d = 1'b1;
                    if (len_bad) begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                        state_d   = S_HUNT;
                    end else begin
                        remain_d = hdr_len[LEN_W-1:0];
                        seq_d    = hdr_seq;
                        acc_d    = 32'd0;
                        state_d  = S_PAY;
                    end
                end
                S_PAY: begin
                    data_d   = t0_data;
                    valid_d  = 1'b1;
                    last_d   = (remain_q == REM_ONE);
                    acc_d    = acc_q + t0_data;
                    remain_d = remain_q - REM_ONE;
                    if (remain_q == REM_ONE) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (t0_data == acc_q) begin
                        ok_d     = 1'b1;
                        ok_cnt_d = sat_inc(ok_cnt_q);
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_HUNT;
            remain_q   <= '0;
            acc_q      <= '0;
            prev_seq_q <= '0;
            seq_seen_q <= 1'b0;
            seq_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            gap_q      <= 1'b0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            acc_q      <= acc_d;
            prev_seq_q <= prev_seq_d;
            seq_seen_q <= seq_seen_d;
            seq_q      <= seq_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            gap_q      <= gap_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign i0_data    = data_q;
    assign i0_valid   = valid_q;
    assign i0_last    = last_q;
    assign frame_seq  = seq_q;
    assign frame_ok   = ok_q;
    assign frame_err  = err_q;
    assign seq_gap    = gap_q;
    assign ok_count   = ok_cnt_q;
    assign err_count  = err_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_word_deframer.sv
// Directed bench for word_deframer: drives framed word streams and checks payload,
// status pulses and counters against hand-computed values.
module tb_word_deframer;

    localparam logic [31:0] SYNC = 32'hC0FFEE5A;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] t0_data = '0;
    logic        t0_valid = 1'b0;
    logic        t0_ready;
    logic [31:0] i0_data;
    logic        i0_valid;
    logic        i0_last;
    logic        i0_ready = 1'b1;
    logic [15:0] frame_seq;
    logic        frame_ok;
    logic        frame_err;
    logic        seq_gap;
    logic [15:0] ok_count;
    logic [15:0] err_count;
    logic [15:0] drop_count;

    word_deframer dut (
        .clk        (clk),
        .reset      (reset),
        .t0_data    (t0_data),
        .t0_valid   (t0_valid),
        .t0_ready   (t0_ready),
        .i0_data    (i0_data),
        .i0_valid   (i0_valid),
        .i0_last    (i0_last),
        .i0_ready   (i0_ready),
        .frame_seq  (frame_seq),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .seq_gap    (seq_gap),
        .ok_count   (ok_count),
        .err_count  (err_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_d[$];
    bit          got_l[$];
    int          got_c[$];
    int          cyc = 0;
    int          ok_n = 0, err_n = 0, gap_n = 0, both_n = 0;
    bit          rdy_random = 1'b0;
    bit          rdy_force  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // i0_ready changes just after the edge so it is settled by the next negedge.
    always @(posedge clk) begin
        #2;
        i0_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    always @(negedge clk) begin
        if (i0_valid && i0_ready) begin
            got_d.push_back(i0_data);
            got_l.push_back(i0_last);
            got_c.push_back(cyc);
        end
        if (frame_ok) ok_n <= ok_n + 1;
        if (frame_err) err_n <= err_n + 1;
        if (seq_gap) gap_n <= gap_n + 1;
        if (frame_ok && frame_err) both_n <= both_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        t0_data  = w;
        t0_valid = 1'b1;
        while (!t0_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("push_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        t0_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (i0_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'(n), 32'd0);
        #1;
    endtask

    task automatic clear_q();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    initial begin
        logic [31:0] sum;
        logic [31:0] w;
        int          mism;
        int          lasts;
        int          ok0, err0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_i0_valid", 32'(i0_valid), 32'd0);
        chk("rst_t0_ready", 32'(t0_ready), 32'd1);
        chk("rst_status", 32'({frame_ok, frame_err, seq_gap, i0_last}), 32'd0);
        chk("rst_counts", 32'({ok_count, err_count}) | 32'(drop_count), 32'd0);
        chk("rst_frame_seq", 32'(frame_seq), 32'd0);
        reset = 1'b1;

        // Good frame, consumer always ready
        push(SYNC);
        push(32'h00030001);
        chk("t1_no_gap", 32'(seq_gap), 32'd0);
        push(32'd1);
        chk("t1_latency_valid", 32'(i0_valid), 32'd1);
        chk("t1_latency_data", i0_data, 32'd1);
        push(32'd2);
        push(32'd3);
        chk("t1_last_word", 32'({i0_last, i0_data[7:0]}), 32'h103);
        push(32'd6);
        chk("t1_frame_ok", 32'({frame_ok, frame_err}), 32'b10);
        chk("t1_ok_count", 32'(ok_count), 32'd1);
        chk("t1_frame_seq", 32'(frame_seq), 32'd1);
        @(posedge clk);
        #1;
        chk("t1_ok_single_pulse", 32'(frame_ok), 32'd0);
        drain();
        chk("t1_n_words", 32'(got_d.size()), 32'd3);
        if (got_d.size() == 3) begin
            chk("t1_data", {got_d[0][7:0], got_d[1][7:0], got_d[2][7:0]} , 32'h010203);
            chk("t1_lasts", 32'({got_l[0], got_l[1], got_l[2]}), 32'b001);
            chk("t1_consecutive", 32'(got_c[2] - got_c[0]), 32'd2);
        end
        clear_q();

        // Garbage ahead of a one-word frame
        push(32'd5);
        push(32'd7);
        push(SYNC);
        push(32'h00010002);
        push(32'hAA);
        push(32'hAA);
        chk("t2_frame_ok", 32'(frame_ok), 32'd1);
        drain();
        chk("t2_drop_count", 32'(drop_count), 32'd2);
        chk("t2_n_words", 32'(got_d.size()), 32'd1);
        if (got_d.size() == 1) chk("t2_word", 32'({got_l[0], got_d[0]}), 32'hAA);
        if (got_l.size() == 1) chk("t2_last", 32'(got_l[0]), 32'd1);
        chk("t2_ok_count", 32'(ok_count), 32'd2);
        clear_q();

        // Back-to-back frames: in-order, then gapped sequence with bad checksum
        push(SYNC);
        push(32'h00020003);
        chk("t3_no_gap", 32'(seq_gap), 32'd0);
        push(32'd10);
        push(32'd20);
        push(32'd30);
        chk("t3a_frame_ok", 32'(frame_ok), 32'd1);
        push(SYNC);
        push(32'h00020005);
        chk("t3_seq_gap", 32'(seq_gap), 32'd1);
        push(32'd100);
        push(32'd200);
        push(32'd301);
        chk("t3b_frame_err", 32'({frame_ok, frame_err}), 32'b01);
        chk("t3_err_count", 32'(err_count), 32'd1);
        drain();
        chk("t3_n_words", 32'(got_d.size()), 32'd4);
        if (got_d.size() == 4) begin
            chk("t3_data", {got_d[0][7:0], got_d[1][7:0], got_d[2][7:0], got_d[3][7:0]},
                32'h0A14_64C8);
            chk("t3_lasts", 32'({got_l[0], got_l[1], got_l[2], got_l[3]}), 32'b0101);
        end
        chk("t3_ok_count", 32'(ok_count), 32'd3);
        clear_q();

        // Bad lengths: zero and MAX_LEN+1
        push(SYNC);
        push(32'h00000005);
        chk("t4_len0_err", 32'(frame_err), 32'd1);
        push(SYNC);
        push(32'h04010005);
        chk("t4_len1025_err", 32'(frame_err), 32'd1);
        chk("t4_err_count", 32'(err_count), 32'd3);
        chk("t4_no_valid", 32'(i0_valid), 32'd0);
        push(SYNC);
        push(32'h00010006);
        chk("t4_seq_after_bad", 32'(seq_gap), 32'd0);
        push(32'd7);
        push(32'd7);
        chk("t4_resync_ok", 32'(frame_ok), 32'd1);
        drain();
        chk("t4_n_words", 32'(got_d.size()), 32'd1);
        chk("t4_drop_count", 32'(drop_count), 32'd2);
        chk("t4_ok_count", 32'(ok_count), 32'd4);
        clear_q();

        // Backpressure stall of 5 cycles mid-payload
        push(SYNC);
        push(32'h00040007);
        push(32'd1);
        rdy_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_stall_flags", 32'({t0_ready, i0_valid, i0_last}), 32'b010);
            chk("t5_stall_data", i0_data, 32'd1);
        end
        rdy_force = 1'b1;
        push(32'd2);
        push(32'd3);
        push(32'd4);
        push(32'd10);
        chk("t5_frame_ok", 32'(frame_ok), 32'd1);
        drain();
        chk("t5_n_words", 32'(got_d.size()), 32'd4);
        if (got_d.size() == 4) begin
            chk("t5_data", {got_d[0][7:0], got_d[1][7:0], got_d[2][7:0], got_d[3][7:0]},
                32'h01020304);
            chk("t5_lasts", 32'({got_l[0], got_l[1], got_l[2], got_l[3]}), 32'b0001);
        end
        clear_q();

        // Maximum-length frame under random backpressure
        rdy_random = 1'b1;
        push(SYNC);
        push(32'h04000008);
        sum = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            w   = 32'(i) * 32'h9E3779B9 + 32'h1234;
            sum = sum + w;
            push(w);
        end
        push(sum);
        chk("t5r_frame_ok", 32'(frame_ok), 32'd1);
        drain();
        rdy_random = 1'b0;
        chk("t5r_n_words", 32'(got_d.size()), 32'd1024);
        mism  = 0;
        lasts = 0;
        for (int i = 0; i < got_d.size(); i++) begin
            if (got_d[i] !== 32'(i) * 32'h9E3779B9 + 32'h1234) mism++;
            if (got_l[i]) lasts++;
        end
        chk("t5r_mismatched_words", 32'(mism), 32'd0);
        chk("t5r_last_count", 32'(lasts), 32'd1);
        if (got_l.size() == 1024) chk("t5r_last_pos", 32'(got_l[1023]), 32'd1);
        chk("t5r_ok_count", 32'(ok_count), 32'd6);
        chk("t5r_frame_seq", 32'(frame_seq), 32'd8);
        clear_q();

        // Reset mid-payload after 2 of 4 words
        ok0  = ok_n;
        err0 = err_n;
        push(SYNC);
        push(32'h00040009);
        push(32'd1);
        push(32'd2);
        reset = 1'b0;
        #1;
        chk("t6_async_valid", 32'({i0_valid, i0_last}), 32'd0);
        chk("t6_counts", 32'({ok_count, err_count}) | 32'(drop_count), 32'd0);
        chk("t6_frame_seq", 32'(frame_seq), 32'd0);
        chk("t6_hunt_ready", 32'(t0_ready), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        clear_q();
        repeat (2) @(negedge clk);
        #1;
        chk("t6_no_status", 32'((ok_n - ok0) + (err_n - err0)), 32'd0);
        push(SYNC);
        push(32'h00020007);
        chk("t6_first_no_gap", 32'(seq_gap), 32'd0);
        push(32'd5);
        push(32'd6);
        push(32'd11);
        chk("t6_frame_ok", 32'(frame_ok), 32'd1);
        drain();
        chk("t6_ok_count", 32'(ok_count), 32'd1);
        chk("t6_frame_seq", 32'(frame_seq), 32'd7);
        chk("t6_n_words", 32'(got_d.size()), 32'd2);
        if (got_d.size() == 2) chk("t6_data", {got_d[0][15:0], got_d[1][15:0]}, 32'h0005_0006);

        chk("gap_pulses", 32'(gap_n), 32'd3);
        chk("ok_err_exclusive", 32'(both_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
